round_sequencer: RTL and testbench

Game controller that sequences the colour-flash display for one Simon Says game. Each round it plays back the first round_len entries of the colour sequence: it drives the sequence index and a flash enable to the flash/display block. It then checks the player's button presses against the same entries. It extends the round on success and reports win/lose. It sits between the top-level game FSM (start, result) and the flash/display datapath (index, flash enable).

---
 rtl/round_seq_pkg.sv | 34 +++
 rtl/round_sequencer_tick_gen.sv | 24 ++
 rtl/round_sequencer.sv | 152 +++++++++++++++
 tb/tb_round_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_seq_pkg.sv
// Shared types and colour helpers for the Simon Says round sequencer.
package round_seq_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SHOW_ON      = 3'd1,
    SHOW_OFF     = 3'd2,
    WAIT_PRESS   = 3'd3,
    WAIT_RELEASE = 3'd4,
    ROUND_OK     = 3'd5,
    WIN          = 3'd6,
    LOSE         = 3'd7
  } state_t;

  // Colour code to button pattern; codes 4..7 have no button, so no press can match them.
  function automatic logic [3:0] code2onehot(input logic [2:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    case (code)
      3'd0:    oh = 4'b0001;
      3'd1:    oh = 4'b0010;
      3'd2:    oh = 4'b0100;
      3'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // True when exactly one button is down.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/round_sequencer_tick_gen.sv
// Free-running prescaler: one-clk tick every CLK_DIV clks, phase fixed only by reset.
module tick_gen #(
  parameter int CLK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Wrap counter; never cleared by the game FSM so tick spacing stays uniform.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Simon Says round sequencer: plays back the colour sequence, checks presses, grows the round.
module round_sequencer
  import round_seq_pkg::*;
#(
  parameter int N_SEG     = 32,
  parameter int CLK_DIV   = 1000000,
  parameter int TICKS_ON  = 10,
  parameter int TICKS_OFF = 5,
  parameter int TIMEOUT   = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N_SEG-1:0][2:0]        segment,
  input  logic [3:0]                   player_input,
  output logic [$clog2(N_SEG)-1:0]     check_round,
  output logic                         flash_en,
  output logic                         accept_input,
  output logic [$clog2(N_SEG+1)-1:0]   round_num,
  output logic                         win,
  output logic                         lose
);

  localparam int IW    = $clog2(N_SEG);
  localparam int RW    = $clog2(N_SEG + 1);
  localparam int T_A   = (TICKS_ON > 2 * TICKS_OFF) ? TICKS_ON : 2 * TICKS_OFF;
  localparam int T_MAX = (T_A > TIMEOUT) ? T_A : TIMEOUT;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(TICKS_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(TICKS_OFF - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(2 * TICKS_OFF - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] LEN_MAX  = RW'(N_SEG);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx;
  logic [RW-1:0] round_len;
  logic [RW-1:0] idx_next;
  logic [3:0]    want;
  logic          tick;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // idx+1 in round_len width so the end-of-round compare never truncates.
  assign idx_next = RW'(idx) + RW'(1);
  assign want     = code2onehot(segment[idx]);

  // Game FSM with tick counter; every transition also clears tcnt for the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      idx       <= '0;
      round_len <= '0;
    end else begin
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state     <= SHOW_ON;
            tcnt      <= '0;
            idx       <= '0;
            round_len <= RW'(1);
          end
        end
        SHOW_ON: begin
          if (tick) begin
            if (tcnt == ON_LAST) begin
              state <= SHOW_OFF;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        SHOW_OFF: begin
          if (tick) begin
            if (tcnt == OFF_LAST) begin
              tcnt <= '0;
              if (idx_next == round_len) begin
                idx   <= '0;
                state <= WAIT_PRESS;
              end else begin
                idx   <= idx + IW'(1);
                state <= SHOW_ON;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        WAIT_PRESS: begin
          // A press outranks a timeout tick landing on the same clk.
          if (player_input != 4'b0000) begin
            tcnt <= '0;
            if (is_onehot(player_input) && (player_input == want)) state <= WAIT_RELEASE;
            else                                                   state <= LOSE;
          end else if (tick) begin
            if (tcnt == TO_LAST) begin
              state <= LOSE;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        WAIT_RELEASE: begin
          if (player_input == 4'b0000) begin
            tcnt <= '0;
            if (idx_next < round_len) begin
              idx   <= idx + IW'(1);
              state <= WAIT_PRESS;
            end else if (round_len == LEN_MAX) begin
              state <= WIN;
            end else begin
              state <= ROUND_OK;
            end
          end
        end
        ROUND_OK: begin
          if (tick) begin
            if (tcnt == GAP_LAST) begin
              state     <= SHOW_ON;
              tcnt      <= '0;
              idx       <= '0;
              round_len <= round_len + RW'(1);
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

  assign flash_en     = (state == SHOW_ON);
  assign accept_input = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign win          = (state == WIN);
  assign lose         = (state == LOSE);
  assign check_round  = idx;
  assign round_num    = round_len;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed steps followed by randomized games against a phase-level model.
module tb_round_sequencer;

  localparam int N_SEG     = 4;
  localparam int CLK_DIV   = 2;
  localparam int TICKS_ON  = 3;
  localparam int TICKS_OFF = 2;
  localparam int TIMEOUT   = 10;
  localparam int IW        = $clog2(N_SEG);
  localparam int RW        = $clog2(N_SEG + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [N_SEG-1:0][2:0] segment;
  logic [3:0]            player_input;
  logic [IW-1:0]         check_round;
  logic                  flash_en;
  logic                  accept_input;
  logic [RW-1:0]         round_num;
  logic                  win;
  logic                  lose;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int seg_m [N_SEG];

  round_sequencer #(
    .N_SEG(N_SEG), .CLK_DIV(CLK_DIV), .TICKS_ON(TICKS_ON),
    .TICKS_OFF(TICKS_OFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .segment      (segment),
    .player_input (player_input),
    .check_round  (check_round),
    .flash_en     (flash_en),
    .accept_input (accept_input),
    .round_num    (round_num),
    .win          (win),
    .lose         (lose)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Button pattern a colour code should be answered with (none for codes 4..7).
  function automatic logic [3:0] exp_onehot(input int code);
    return (code < 4) ? 4'(1 << code) : 4'b0000;
  endfunction

  // Cycles a tick-timed phase lasts when it starts in cycle cyc. Ticks fall in
  // cycles t with t % CLK_DIV == CLK_DIV-1, counting clk edges since reset release.
  function automatic int dur(input int n);
    int s, f;
    s = cyc;
    f = s + ((CLK_DIV - 1) - (s % CLK_DIV));
    return f + (n - 1) * CLK_DIV - s + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic align();
    while ((cyc % CLK_DIV) != (CLK_DIV - 1)) step();
  endtask

  task automatic load_seg();
    for (int i = 0; i < N_SEG; i++) segment[i] = 3'(seg_m[i]);
  endtask

  task automatic check_outs(input string tag, input logic fl, input logic acc, input int cr,
                            input int rn, input logic w, input logic l);
    logic [15:0] obs, exp;
    obs = {4'b0, flash_en, accept_input, win, lose, 4'(check_round), 4'(round_num)};
    exp = {4'b0, fl, acc, w, l, 4'(cr), 4'(rn)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: got fl=%b acc=%b win=%b lose=%b cr=%0d rn=%0d, expected fl=%b acc=%b win=%b lose=%b cr=%0d rn=%0d",
             tag, cyc, flash_en, accept_input, win, lose, check_round, round_num, fl, acc, w, l, cr, rn);
    end
  endtask

  task automatic hold(input string tag, input int n, input logic fl, input logic acc, input int cr,
                      input int rn, input logic w, input logic l);
    for (int i = 0; i < n; i++) begin
      check_outs(tag, fl, acc, cr, rn, w, l);
      step();
    end
  endtask

  // One game from IDLE/WIN/LOSE. Presses are numbered p = 0,1,2,... across the game;
  // at press fail_at: kind 1 = wrong press (bad, or random if bad is unusable),
  // kind 2 = never press (timeout), kind 3 = correct press on the timeout tick itself.
  task automatic play_game(input int fail_at, input int kind, input logic [3:0] bad);
    int p;
    int d;
    logic [3:0] want;
    logic [3:0] v;
    p = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int rl = 1; rl <= N_SEG; rl++) begin
      for (int i = 0; i < rl; i++) begin
        hold("show_on", dur(TICKS_ON), 1'b1, 1'b0, i, rl, 1'b0, 1'b0);
        hold("show_off", dur(TICKS_OFF), 1'b0, 1'b0, i, rl, 1'b0, 1'b0);
      end
      for (int i = 0; i < rl; i++) begin
        want = exp_onehot(seg_m[i]);
        if (p == fail_at && kind == 2) begin
          hold("wait_timeout", dur(TIMEOUT), 1'b0, 1'b1, i, rl, 1'b0, 1'b0);
          check_outs("timeout_lose", 1'b0, 1'b0, i, rl, 1'b0, 1'b1);
          return;
        end
        if (p == fail_at && kind == 3) d = dur(TIMEOUT) - 1;
        else                           d = $urandom_range(1, 4);
        hold("wait_press", d, 1'b0, 1'b1, i, rl, 1'b0, 1'b0);
        if (p == fail_at && kind == 1) begin
          v = bad;
          if (v == want || v == 4'b0000) begin
            do v = 4'($urandom_range(1, 15)); while (v == want);
          end
        end else begin
          v = want;
          if (v == 4'b0000) v = 4'($urandom_range(1, 15));
        end
        player_input = v;
        step();
        if (v != want) begin
          player_input = 4'b0000;
          hold("press_lose", 2, 1'b0, 1'b0, i, rl, 1'b0, 1'b1);
          return;
        end
        hold("wait_release", $urandom_range(1, 3), 1'b0, 1'b1, i, rl, 1'b0, 1'b0);
        player_input = 4'($urandom_range(1, 15));
        hold("held_change", $urandom_range(0, 2), 1'b0, 1'b1, i, rl, 1'b0, 1'b0);
        player_input = 4'b0000;
        step();
        p++;
      end
      if (rl == N_SEG) begin
        hold("win", 2, 1'b0, 1'b0, rl - 1, rl, 1'b1, 1'b0);
        return;
      end
      hold("round_ok", dur(2 * TICKS_OFF), 1'b0, 1'b0, rl - 1, rl, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    player_input = 4'b0000;
    seg_m        = '{0, 1, 2, 3};
    load_seg();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_state", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc   = 0;
    hold("idle_no_start", 4, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // First round playback with start sampled on a tick: 6 clks lit, 4 dark.
    align();
    start = 1'b1;
    step();
    start = 1'b0;
    hold("t2_on", 6, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    hold("t2_off", 4, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    check_outs("t2_wait", 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("start_ignored", 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);

    // Correct press, release on a tick: 8 clks of ROUND_OK then two flashes.
    player_input = 4'b0001;
    step();
    check_outs("t3_held", 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
    align();
    player_input = 4'b0000;
    step();
    hold("t3_round_ok", 8, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    hold("t3_on0", 6, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
    hold("t3_off0", 4, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0);
    hold("t3_on1", 6, 1'b1, 1'b0, 1, 2, 1'b0, 1'b0);
    hold("t3_off1", 4, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0);
    check_outs("t3_wait", 1'b0, 1'b1, 0, 2, 1'b0, 1'b0);

    // Round 2: first press right, second expects 0010 but gets 0100.
    player_input = 4'b0001;
    step();
    player_input = 4'b0000;
    step();
    check_outs("t5_wait_idx1", 1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
    player_input = 4'b0100;
    step();
    player_input = 4'b0000;
    hold("t5_wrong_lose", 3, 1'b0, 1'b0, 1, 2, 1'b0, 1'b1);

    // Async reset in the middle of round-2 playback.
    align();
    start = 1'b1;
    step();
    start = 1'b0;
    hold("t1_on", 6, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    hold("t1_off", 4, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    player_input = 4'b0001;
    step();
    align();
    player_input = 4'b0000;
    step();
    hold("t1_round_ok", 8, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    hold("t1_on_r2", 3, 1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outs("t1_async_reset", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    step();
    check_outs("t1_in_reset", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc   = 0;
    hold("t1_idle_after", 6, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Full winning game, then a restart from WIN that wins again.
    play_game(-1, 0, 4'b0000);
    play_game(-1, 0, 4'b0000);
    // Two buttons at once where 0010 is expected.
    play_game(2, 1, 4'b0011);
    // Timeout in round 1, and a press landing on the timeout tick.
    play_game(0, 2, 4'b0000);
    play_game(3, 3, 4'b0000);
    // Invalid colour code at index 0: any press loses.
    seg_m[0] = 5;
    load_seg();
    play_game(-1, 0, 4'b0000);

    // Random sequences and failure points.
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < N_SEG; i++)
        seg_m[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      load_seg();
      play_game($urandom_range(0, 9), $urandom_range(0, 3), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
